bram_pixel_streamer: RTL and testbench



---
 rtl/bram_pixel_streamer.sv | 142 ++++++++++++++
 tb/tb_bram_pixel_streamer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_pixel_streamer.sv
// Read sequencer for BRAM port B: fetches each frame word, waits out the read
// latency, then streams its four bytes (LSB first) over a valid/ready handshake.
module bram_pixel_streamer #(
    parameter int ADDR_W    = 16,
    parameter int NUM_WORDS = 16384,
    parameter int READ_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [31:0]       doutb,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, SEND} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [1:0]        LAT_LAST  = 2'(READ_LAT - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [1:0]        lat_reg, lat_next;
    logic [1:0]        byte_reg, byte_next;
    logic [31:0]       word_reg, word_next;
    logic              done_reg, done_next;
    logic              busy_reg, busy_next;
    logic              enb_reg, enb_next;
    logic              pix_valid_reg, pix_valid_next;
    logic [7:0]        pix_data_reg, pix_data_next;
    logic              pix_last_reg, pix_last_next;
    logic              xfer;
    logic [7:0]        word_bytes [4];

    // Byte lanes of the word that will be held next cycle, so a fresh capture
    // from doutb can be presented on the very first SEND cycle.
    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
        assign word_bytes[gi] = word_next[8*gi +: 8];
    end

    assign xfer = pix_valid_reg & pix_ready;

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        lat_next   = lat_reg;
        byte_next  = byte_reg;
        word_next  = word_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                    addr_next  = '0;
                end
            end
            FETCH: begin
                state_next = WAIT;
                lat_next   = 2'd0;
            end
            WAIT: begin
                if (lat_reg == LAT_LAST) begin
                    word_next  = doutb;
                    byte_next  = 2'd0;
                    state_next = SEND;
                end else begin
                    lat_next = lat_reg + 2'd1;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (byte_reg != 2'd3) begin
                        byte_next = byte_reg + 2'd1;
                    end else if (addr_reg != LAST_ADDR) begin
                        addr_next  = addr_reg + ADDR_W'(1);
                        state_next = FETCH;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next-state values so they are all flops.
    always_comb begin
        busy_next      = (state_next != IDLE);
        enb_next       = (state_next == FETCH);
        pix_valid_next = (state_next == SEND);
        pix_data_next  = pix_data_reg;
        pix_last_next  = 1'b0;
        if (state_next == SEND) begin
            pix_data_next = word_bytes[byte_next];
            pix_last_next = (byte_next == 2'd3) && (addr_next == LAST_ADDR);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            lat_reg       <= 2'd0;
            byte_reg      <= 2'd0;
            word_reg      <= 32'd0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            enb_reg       <= 1'b0;
            pix_valid_reg <= 1'b0;
            pix_data_reg  <= 8'd0;
            pix_last_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            lat_reg       <= lat_next;
            byte_reg      <= byte_next;
            word_reg      <= word_next;
            done_reg      <= done_next;
            busy_reg      <= busy_next;
            enb_reg       <= enb_next;
            pix_valid_reg <= pix_valid_next;
            pix_data_reg  <= pix_data_next;
            pix_last_reg  <= pix_last_next;
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign enb       = enb_reg;
    assign addrb     = addr_reg;
    assign pix_valid = pix_valid_reg;
    assign pix_data  = pix_data_reg;
    assign pix_last  = pix_last_reg;

endmodule

// File: tb/tb_bram_pixel_streamer.sv
// Three streamer instances (4 words/lat 1, 4 words/lat 2, 1 word/lat 1), each
// with a BRAM model, checked every cycle against a frame-level reference.
module tb_bram_pixel_streamer;

    function automatic int nw_of(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    function automatic int rl_of(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    logic        clk = 1'b0;
    logic        rst_s [3];
    logic        start_s [3];
    logic        rdy [3];
    logic        busy_w [3];
    logic        done_w [3];
    logic        enb_w [3];
    logic [15:0] addrb_w [3];
    logic [31:0] doutb_w [3];
    logic [7:0]  pd_w [3];
    logic        pv_w [3];
    logic        pl_w [3];
    logic [31:0] mem [3][4];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // reference state per instance
    bit m_seen [3];
    bit m_rst_prev [3];
    bit m_active [3];
    int m_fetch_at [3];
    int m_w [3];
    int m_pos [3];
    int m_done_at [3];

    // observation logs for the literal checks
    logic [7:0]  log_b [3][64];
    int          log_n [3];
    int          enb_cyc [3][16];
    logic [15:0] enb_addr [3][16];
    int          enb_n [3];
    int          first_valid [3];
    int          last_xfer [3];
    int          done_cyc [3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int NWL = nw_of(gi);
        localparam int RLL = rl_of(gi);
        logic        s1_v, s2_v;
        logic [31:0] s1_d, s2_d, junk;

        bram_pixel_streamer #(.ADDR_W(16), .NUM_WORDS(NWL), .READ_LAT(RLL)) u_dut (
            .clk(clk), .rst(rst_s[gi]), .start(start_s[gi]),
            .busy(busy_w[gi]), .done(done_w[gi]), .enb(enb_w[gi]),
            .addrb(addrb_w[gi]), .doutb(doutb_w[gi]),
            .pix_data(pd_w[gi]), .pix_valid(pv_w[gi]), .pix_ready(rdy[gi]),
            .pix_last(pl_w[gi])
        );

        // read data is only valid for the one cycle the latency implies
        always @(posedge clk) begin
            s1_v <= enb_w[gi];
            s1_d <= mem[gi][addrb_w[gi][1:0]];
            s2_v <= s1_v;
            s2_d <= s1_d;
            junk <= $urandom;
        end
        assign doutb_w[gi] = (RLL == 1) ? (s1_v ? s1_d : junk) : (s2_v ? s2_d : junk);
    end

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", name, d, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name, input int d);
        checks++;
        failures++;
        $display("FAIL %s dut%0d cyc=%0d got=timeout expected=event", name, d, cyc);
    endtask

    always @(negedge clk) begin
        logic        exp_enb, exp_valid, idle;
        logic [31:0] word;
        logic [7:0]  exp_byte;
        int          nw;
        for (int d = 0; d < 3; d++) begin
            nw = nw_of(d);
            exp_enb   = m_active[d] && (cyc == m_fetch_at[d]);
            exp_valid = m_active[d] && (cyc >= m_fetch_at[d] + 1 + rl_of(d));
            exp_byte  = 8'd0;
            if (exp_valid) begin
                word     = mem[d][(m_pos[d] / 4) % 4];
                exp_byte = word[8*(m_pos[d] % 4) +: 8];
            end
            if (m_seen[d]) begin
                if (m_rst_prev[d]) begin
                    chk("rst_addrb", d, 32'(addrb_w[d]), 32'd0);
                    chk("rst_pix_data", d, 32'(pd_w[d]), 32'd0);
                    chk("rst_pix_last", d, 32'(pl_w[d]), 32'd0);
                end
                chk("enb", d, 32'(enb_w[d]), 32'(exp_enb));
                if (exp_enb) chk("addrb", d, 32'(addrb_w[d]), 32'(m_w[d]));
                chk("pix_valid", d, 32'(pv_w[d]), 32'(exp_valid));
                if (exp_valid) begin
                    chk("pix_data", d, 32'(pd_w[d]), 32'(exp_byte));
                    chk("pix_last", d, 32'(pl_w[d]), 32'(m_pos[d] == 4*nw - 1));
                end
                chk("busy", d, 32'(busy_w[d]), 32'(m_active[d]));
                chk("done", d, 32'(done_w[d]), 32'(cyc == m_done_at[d]));
                if (!rst_s[d]) begin
                    if (enb_w[d] && enb_n[d] < 16) begin
                        enb_cyc[d][enb_n[d]]  = cyc;
                        enb_addr[d][enb_n[d]] = addrb_w[d];
                        enb_n[d]++;
                    end
                    if (pv_w[d] && first_valid[d] < 0) first_valid[d] = cyc;
                    if (pv_w[d] && rdy[d]) begin
                        if (log_n[d] < 64) begin
                            log_b[d][log_n[d]] = pd_w[d];
                            log_n[d]++;
                        end
                        last_xfer[d] = cyc;
                    end
                    if (done_w[d]) done_cyc[d] = cyc;
                end
            end
            if (rst_s[d]) begin
                m_active[d]   = 1'b0;
                m_done_at[d]  = -1;
                m_rst_prev[d] = 1'b1;
                m_seen[d]     = 1'b1;
            end else if (m_seen[d]) begin
                idle          = !m_active[d];
                m_rst_prev[d] = 1'b0;
                if (exp_valid && rdy[d]) begin
                    m_pos[d]++;
                    if (m_pos[d] % 4 == 0) begin
                        if (m_pos[d] == 4*nw) begin
                            m_active[d]  = 1'b0;
                            m_done_at[d] = cyc + 1;
                        end else begin
                            m_w[d]++;
                            m_fetch_at[d] = cyc + 1;
                        end
                    end
                end
                if (idle && start_s[d]) begin
                    m_active[d]   = 1'b1;
                    m_w[d]        = 0;
                    m_pos[d]      = 0;
                    m_fetch_at[d] = cyc + 1;
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log(input int d);
        log_n[d]       = 0;
        enb_n[d]       = 0;
        first_valid[d] = -1;
        last_xfer[d]   = -1;
        done_cyc[d]    = -1;
    endtask

    task automatic pulse_start(input int d);
        start_s[d] = 1'b1;
        tick();
        start_s[d] = 1'b0;
    endtask

    task automatic wait_byte(input int d, input logic [7:0] b);
        for (int k = 0; k < 400; k++) begin
            if (pv_w[d] && pd_w[d] == b) return;
            tick();
        end
        timeout_fail("wait_byte", d);
    endtask

    task automatic wait_done(input int d);
        for (int k = 0; k < 400; k++) begin
            if (done_w[d]) return;
            tick();
        end
        timeout_fail("wait_done", d);
    endtask

    task automatic check_ramp(input string name, input int d);
        chk({name, "_count"}, d, 32'(log_n[d]), 32'd16);
        for (int i = 0; i < 16; i++) chk(name, d, 32'(log_b[d][i]), 32'(i));
    endtask

    initial begin
        logic [7:0] exp2 [4];
        exp2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int d = 0; d < 3; d++) begin
            rst_s[d] = 1'b1; start_s[d] = 1'b0; rdy[d] = 1'b1;
            m_seen[d] = 1'b0; m_rst_prev[d] = 1'b0; m_active[d] = 1'b0;
            m_fetch_at[d] = -10; m_w[d] = 0; m_pos[d] = 0; m_done_at[d] = -1;
            clear_log(d);
            for (int i = 0; i < 4; i++)
                mem[d][i] = (d == 2) ? 32'd0 : 32'h03020100 + 32'(i) * 32'h04040404;
        end
        mem[2][0] = 32'hDDCCBBAA;
        repeat (3) tick();
        for (int d = 0; d < 3; d++) rst_s[d] = 1'b0;
        tick();

        // basic frame on all three instances
        for (int d = 0; d < 3; d++) start_s[d] = 1'b1;
        tick();
        for (int d = 0; d < 3; d++) start_s[d] = 1'b0;
        wait_done(1);
        repeat (3) tick();
        check_ramp("basic_byte", 0);
        chk("basic_enb_count", 0, 32'(enb_n[0]), 32'd4);
        for (int i = 0; i < 4; i++) chk("basic_enb_addr", 0, 32'(enb_addr[0][i]), 32'(i));
        chk("first_valid_lat", 0, 32'(first_valid[0] - enb_cyc[0][0]), 32'd2);
        chk("done_after_last", 0, 32'(done_cyc[0] - last_xfer[0]), 32'd1);
        check_ramp("lat2_byte", 1);
        chk("lat2_word_period", 1, 32'(enb_cyc[1][1] - enb_cyc[1][0]), 32'd7);
        chk("lat2_first_valid", 1, 32'(first_valid[1] - enb_cyc[1][0]), 32'd3);
        chk("single_count", 2, 32'(log_n[2]), 32'd4);
        for (int i = 0; i < 4; i++) chk("single_byte", 2, 32'(log_b[2][i]), 32'(exp2[i]));
        chk("single_enb_count", 2, 32'(enb_n[2]), 32'd1);
        chk("single_done", 2, 32'(done_cyc[2] - last_xfer[2]), 32'd1);

        // backpressure on 0x06
        clear_log(0);
        pulse_start(0);
        wait_byte(0, 8'h06);
        rdy[0] = 1'b0;
        repeat (5) tick();
        rdy[0] = 1'b1; tick();
        rdy[0] = 1'b0; tick();
        rdy[0] = 1'b1;
        wait_done(0);
        tick();
        check_ramp("bp_byte", 0);
        chk("bp_enb_count", 0, 32'(enb_n[0]), 32'd4);

        // start ignored mid-frame, accepted in the done cycle
        clear_log(0);
        pulse_start(0);
        wait_byte(0, 8'h04);
        pulse_start(0);
        wait_done(0);
        pulse_start(0);
        wait_done(0);
        tick();
        chk("restart_count", 0, 32'(log_n[0]), 32'd32);
        chk("restart_first", 0, 32'(log_b[0][16]), 32'd0);
        chk("restart_enb_count", 0, 32'(enb_n[0]), 32'd8);
        chk("restart_addr0", 0, 32'(enb_addr[0][4]), 32'd0);

        // reset while 0x06 is valid
        pulse_start(0);
        wait_byte(0, 8'h06);
        rst_s[0] = 1'b1;
        tick();
        rst_s[0] = 1'b0;
        chk("rst_valid", 0, 32'(pv_w[0]), 32'd0);
        chk("rst_busy", 0, 32'(busy_w[0]), 32'd0);
        clear_log(0);
        repeat (10) tick();
        chk("rst_no_done", 0, 32'(done_cyc[0]), 32'hFFFF_FFFF);
        chk("rst_no_enb", 0, 32'(enb_n[0]), 32'd0);
        pulse_start(0);
        wait_done(0);
        tick();
        check_ramp("replay_byte", 0);

        // randomized traffic against the reference
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 4; i++) mem[d][i] = $urandom;
        for (int k = 0; k < 3000; k++) begin
            for (int d = 0; d < 3; d++) begin
                rdy[d]     = ($urandom_range(3) != 0);
                start_s[d] = ($urandom_range(9) == 0);
                rst_s[d]   = ($urandom_range(399) == 0);
            end
            tick();
        end
        for (int d = 0; d < 3; d++) begin
            rdy[d] = 1'b1; start_s[d] = 1'b0; rst_s[d] = 1'b0;
        end
        repeat (80) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
